// File: rtl/bram_reduce_if.sv
// PS-facing bus of bram_reduce: GPIO control/status word pair plus the
// AXI BRAM controller data port (byte addressed, per-byte write enables).
interface bram_reduce_if #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 2048
);
  localparam int ADDR_W = $clog2(DEPTH) + $clog2(DATA_W / 8);

  logic [31:0]           ps_control;
  logic [31:0]           pl_status;
  logic [ADDR_W-1:0]     ps_bram_addr;
  logic [DATA_W-1:0]     ps_bram_rddata;
  logic [DATA_W-1:0]     ps_bram_wrdata;
  logic [DATA_W/8-1:0]   ps_bram_we;
  logic                  ps_bram_en;

  modport master (
    output ps_control,
    output ps_bram_addr,
    output ps_bram_wrdata,
    output ps_bram_we,
    output ps_bram_en,
    input  pl_status,
    input  ps_bram_rddata
  );

  modport slave (
    input  ps_control,
    input  ps_bram_addr,
    input  ps_bram_wrdata,
    input  ps_bram_we,
    input  ps_bram_en,
    output pl_status,
    output ps_bram_rddata
  );
endinterface

// File: rtl/bram_reduce.sv
// Dual-port BRAM shared with the PS plus a PL engine that reduces words 0..N-1
// (max unsigned, max signed, min unsigned, wrapping sum) and writes the result to word 0.
module bram_reduce #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 2048
) (
  input  logic         clk,
  input  logic         reset,
  bram_reduce_if.slave bus
);

  localparam int BYTES  = DATA_W / 8;
  localparam int BOFF   = $clog2(BYTES);
  localparam int WA     = $clog2(DEPTH);
  localparam int ADDR_W = WA + BOFF;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_READ  = 3'd1;
  localparam logic [2:0] S_DRAIN = 3'd2;
  localparam logic [2:0] S_WRITE = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [1:0] OP_MAXU = 2'b00;
  localparam logic [1:0] OP_MAXS = 2'b01;
  localparam logic [1:0] OP_MINU = 2'b10;
  localparam logic [1:0] OP_SUM  = 2'b11;

  logic [DATA_W-1:0] mem [DEPTH];

  logic [2:0]        state_q, state_d;
  logic [1:0]        op_q;
  logic [15:0]       lastIdx_q;
  logic [15:0]       issueIdx_q;
  logic              err_q;
  logic              rdValid_q;
  logic [15:0]       rdIdx_q;
  logic [DATA_W-1:0] rdData_q;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [15:0]       idx_q, idx_d;
  logic [DATA_W-1:0] psRdData_q;
  logic [31:0]       status_q;

  logic              start;
  logic [1:0]        opIn;
  logic [16:0]       nEff;
  logic              nValid;
  logic [WA-1:0]     psWord;
  logic              better;
  logic              busy;
  logic              unusedBits;

  assign start  = bus.ps_control[0];
  assign opIn   = bus.ps_control[2:1];
  assign nEff   = (bus.ps_control[31:16] == 16'd0) ? 17'(DEPTH) : {1'b0, bus.ps_control[31:16]};
  assign nValid = (nEff <= 17'(DEPTH));
  assign psWord = bus.ps_bram_addr[ADDR_W-1:BOFF];
  assign busy   = (state_q == S_READ) || (state_q == S_DRAIN) || (state_q == S_WRITE);

  assign unusedBits = ^{bus.ps_control[15:3], bus.ps_bram_addr, issueIdx_q};

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start) state_d = nValid ? S_READ : S_DONE;
      S_READ:  if (issueIdx_q == lastIdx_q) state_d = S_DRAIN;
      S_DRAIN: state_d = S_WRITE;
      S_WRITE: state_d = S_DONE;
      S_DONE:  if (!start) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // op and N are captured only when a start is accepted in IDLE.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      op_q       <= OP_MAXU;
      lastIdx_q  <= '0;
      issueIdx_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == S_IDLE && start) begin
        op_q       <= opIn;
        lastIdx_q  <= 16'(nEff - 17'd1);
        issueIdx_q <= '0;
        err_q      <= !nValid;
      end else if (state_q == S_READ) begin
        issueIdx_q <= issueIdx_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rdValid_q <= 1'b0;
      rdIdx_q   <= '0;
    end else begin
      rdValid_q <= (state_q == S_READ);
      rdIdx_q   <= issueIdx_q;
    end
  end

  always_ff @(posedge clk) begin
    if (state_q == S_READ) rdData_q <= mem[issueIdx_q[WA-1:0]];
  end

  always_comb begin
    better = 1'b0;
    unique case (op_q)
      OP_MAXU: better = (rdData_q > acc_q);
      OP_MAXS: better = ($signed(rdData_q) > $signed(acc_q));
      OP_MINU: better = (rdData_q < acc_q);
      default: better = 1'b0;
    endcase
  end

  // Strict comparison means a tie never replaces the earlier (lower) index.
  always_comb begin
    acc_d = acc_q;
    idx_d = idx_q;
    if (rdValid_q) begin
      if (rdIdx_q == 16'd0) begin
        acc_d = rdData_q;
        idx_d = '0;
      end else if (op_q == OP_SUM) begin
        acc_d = acc_q + rdData_q;
      end else if (better) begin
        acc_d = rdData_q;
        idx_d = rdIdx_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q <= '0;
      idx_q <= '0;
    end else begin
      acc_q <= acc_d;
      idx_q <= idx_d;
    end
  end

  // Engine write-back is issued after the PS write so it wins a word-0 collision.
  always_ff @(posedge clk) begin
    if (bus.ps_bram_en) begin
      for (int b = 0; b < BYTES; b++) begin
        if (bus.ps_bram_we[b]) mem[psWord][b*8 +: 8] <= bus.ps_bram_wrdata[b*8 +: 8];
      end
    end
    if (state_q == S_WRITE && !reset) mem[0] <= acc_q;
  end

  always_ff @(posedge clk) begin
    if (reset)               psRdData_q <= '0;
    else if (bus.ps_bram_en) psRdData_q <= mem[psWord];
  end

  always_ff @(posedge clk) begin
    if (reset) status_q <= '0;
    else       status_q <= {idx_q, 13'd0, err_q, busy, (state_q == S_DONE)};
  end

  assign bus.ps_bram_rddata = psRdData_q;
  assign bus.pl_status      = status_q;

endmodule

// File: tb/tb_bram_reduce.sv
// Self-checking bench for bram_reduce: table-driven reductions scored through a
// queue, plus hand sequences for errors, hold-start, collisions and reset abort.
module tb_bram_reduce;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 2048;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  bram_reduce_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

  bram_reduce #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0] res;
    logic [15:0] idx;
    int          n;
  } exp_t;

  typedef struct {
    logic [31:0] w0, w1, w2, w3;
    logic [1:0]  op;
    logic [15:0] n;
    logic [31:0] expRes;
    logic [15:0] expIdx;
  } vec_t;

  exp_t sbQ[$];
  vec_t vecs[10];
  int   nTests = 0;
  int   nFail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    nTests++;
    if (act !== want) begin
      nFail++;
      $display("[TB] FAIL %s: got %h, want %h", name, act, want);
    end
  endtask

  task automatic psWrite(input int word, input logic [31:0] data);
    bus.ps_bram_en     = 1'b1;
    bus.ps_bram_we     = 4'hF;
    bus.ps_bram_addr   = 13'(word << 2);
    bus.ps_bram_wrdata = data;
    @(negedge clk);
    bus.ps_bram_en = 1'b0;
    bus.ps_bram_we = 4'h0;
  endtask

  task automatic psRead(input int word, output logic [31:0] data);
    bus.ps_bram_en   = 1'b1;
    bus.ps_bram_we   = 4'h0;
    bus.ps_bram_addr = 13'(word << 2);
    @(negedge clk);
    data = bus.ps_bram_rddata;
    bus.ps_bram_en = 1'b0;
  endtask

  task automatic applyStimulus(input logic [1:0] op, input logic [15:0] nField,
                               input logic [31:0] res, input logic [15:0] idx,
                               input bit holdStart);
    exp_t e;
    e.res = res;
    e.idx = idx;
    e.n   = (nField == 16'd0) ? DEPTH : int'(nField);
    sbQ.push_back(e);
    bus.ps_control = {nField, 13'd0, op, 1'b1};
    @(negedge clk);
    if (!holdStart) bus.ps_control[0] = 1'b0;
  endtask

  task automatic checkOutput(input string name, input bit holdStart);
    exp_t        e;
    int          edges;
    logic [31:0] st, first, w;
    if (sbQ.size() == 0) begin
      check({name, "-queue"}, 32'd0, 32'd1);
      return;
    end
    e = sbQ.pop_front();
    edges = 0;
    first = '0;
    do begin
      @(negedge clk);
      edges++;
      if (edges == 1) first = bus.pl_status;
    end while (!bus.pl_status[0] && edges < e.n + 20);
    st = bus.pl_status;
    check({name, "-busy"},    {31'd0, first[1]}, 32'd1);
    check({name, "-latency"}, 32'(edges), 32'(e.n + 3));
    check({name, "-idx"},     {16'd0, st[31:16]}, {16'd0, e.idx});
    check({name, "-err"},     {31'd0, st[2]}, 32'd0);
    if (holdStart) begin
      repeat (4) @(negedge clk);
      check({name, "-holddone"}, {30'd0, bus.pl_status[1:0]}, 32'd1);
    end
    bus.ps_control = '0;
    repeat (2) @(negedge clk);
    check({name, "-donefall"}, {31'd0, bus.pl_status[0]}, 32'd0);
    psRead(0, w);
    check({name, "-word0"}, w, e.res);
  endtask

  initial begin
    logic [31:0] w;

    vecs[0] = '{32'd5, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFF7, 2'b01, 16'd4, 32'd7, 16'd2};
    vecs[1] = '{32'd5, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFF7, 2'b00, 16'd4, 32'hFFFF_FFFD, 16'd1};
    vecs[2] = '{32'd9, 32'd2, 32'd2, 32'd4, 2'b10, 16'd4, 32'd2, 16'd1};
    vecs[3] = '{32'hFFFF_FFFF, 32'd2, 32'd3, 32'd0, 2'b11, 16'd3, 32'd4, 16'd0};
    vecs[4] = '{32'hFFFF_FFFF, 32'd2, 32'd3, 32'd0, 2'b11, 16'd1, 32'hFFFF_FFFF, 16'd0};
    vecs[5] = '{32'd5, 32'd9, 32'd9, 32'd1, 2'b00, 16'd4, 32'd9, 16'd1};
    vecs[6] = '{32'd3, 32'd8, 32'd1, 32'd8, 2'b10, 16'd4, 32'd1, 16'd2};
    vecs[7] = '{32'h8000_0000, 32'h7FFF_FFFF, 32'd0, 32'd1, 2'b01, 16'd4, 32'h7FFF_FFFF, 16'd1};
    vecs[8] = '{32'h8000_0000, 32'h7FFF_FFFF, 32'd0, 32'd1, 2'b00, 16'd4, 32'h8000_0000, 16'd0};
    vecs[9] = '{32'd1, 32'd2, 32'd3, 32'd4, 2'b11, 16'd4, 32'd10, 16'd0};

    reset              = 1'b1;
    bus.ps_control     = '0;
    bus.ps_bram_en     = 1'b0;
    bus.ps_bram_we     = '0;
    bus.ps_bram_addr   = '0;
    bus.ps_bram_wrdata = '0;
    repeat (3) @(negedge clk);
    check("reset-status", bus.pl_status, 32'd0);
    check("reset-rddata", bus.ps_bram_rddata, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 10; i++) begin
      psWrite(0, vecs[i].w0);
      psWrite(1, vecs[i].w1);
      psWrite(2, vecs[i].w2);
      psWrite(3, vecs[i].w3);
      applyStimulus(vecs[i].op, vecs[i].n, vecs[i].expRes, vecs[i].expIdx, 1'b0);
      checkOutput($sformatf("vec%0d", i), 1'b0);
    end

    psWrite(5, 32'h1122_3344);
    bus.ps_bram_en     = 1'b1;
    bus.ps_bram_we     = 4'b0101;
    bus.ps_bram_addr   = 13'(5 << 2);
    bus.ps_bram_wrdata = 32'hAABB_CCDD;
    @(negedge clk);
    check("readfirst", bus.ps_bram_rddata, 32'h1122_3344);
    bus.ps_bram_en = 1'b0;
    bus.ps_bram_we = 4'h0;
    psRead(5, w);
    check("bytemask", w, 32'h11BB_33DD);

    psWrite(0, 32'hCAFE_0001);
    bus.ps_control = {16'd4096, 13'd0, 2'b00, 1'b1};
    repeat (3) @(negedge clk);
    check("err-status", {29'd0, bus.pl_status[2:0]}, 32'd5);
    bus.ps_control = '0;
    repeat (2) @(negedge clk);
    check("err-donefall", {31'd0, bus.pl_status[0]}, 32'd0);
    psRead(0, w);
    check("err-word0", w, 32'hCAFE_0001);

    psWrite(0, 32'd4);
    psWrite(1, 32'd6);
    applyStimulus(2'b10, 16'd2, 32'd4, 16'd0, 1'b1);
    checkOutput("holdstart", 1'b1);

    psWrite(0, 32'd10);
    psWrite(1, 32'd20);
    psWrite(2, 32'd30);
    bus.ps_control = {16'd3, 13'd0, 2'b00, 1'b1};
    @(negedge clk);
    bus.ps_control[0] = 1'b0;
    repeat (4) @(negedge clk);
    bus.ps_bram_en     = 1'b1;
    bus.ps_bram_we     = 4'hF;
    bus.ps_bram_addr   = '0;
    bus.ps_bram_wrdata = 32'hDEAD_BEEF;
    @(negedge clk);
    bus.ps_bram_en = 1'b0;
    bus.ps_bram_we = 4'h0;
    @(negedge clk);
    check("collide-done", {31'd0, bus.pl_status[0]}, 32'd1);
    repeat (2) @(negedge clk);
    psRead(0, w);
    check("collide-word0", w, 32'd30);

    for (int i = 0; i < DEPTH - 1; i++) psWrite(i, $urandom & 32'hFFFF_FFFE);
    psWrite(DEPTH - 1, 32'hFFFF_FFFF);
    applyStimulus(2'b00, 16'd0, 32'hFFFF_FFFF, 16'd2047, 1'b0);
    checkOutput("full", 1'b0);

    psWrite(0, 32'h1234_5678);
    bus.ps_control = {16'd0, 13'd0, 2'b00, 1'b1};
    @(negedge clk);
    repeat (10) @(negedge clk);
    reset          = 1'b1;
    bus.ps_control = '0;
    @(negedge clk);
    check("abort-status", bus.pl_status, 32'd0);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    psRead(0, w);
    check("abort-word0", w, 32'h1234_5678);
    applyStimulus(2'b00, 16'd0, 32'hFFFF_FFFF, 16'd2047, 1'b0);
    checkOutput("rerun", 1'b0);

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
